// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared fetch-stage constants and payload types
//
// Package: defines
//   DATA_WIDTH      width of PC and instruction word
//   FETCH_BUF_DEPTH default number of fetch buffer entries
//   fetch_entry_t   {pc, instr} pair, used for buffer storage and the IF/ID payload
package defines;

  localparam int DATA_WIDTH      = 32;
  localparam int FETCH_BUF_DEPTH = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - fetch-to-decode decoupling FIFO with PC stall and flush
//
// Circular first-word-fall-through FIFO of {pc, instr} pairs between the
// program counter and Decode. A full buffer drops pc_en_o to stall PC advance;
// flush_i empties the buffer in one cycle.
//
// Optional feature macro: FETCH_BUF_PERF_EN
//   defined   : perf_stall_cnt_o counts saturating stall cycles, cleared by rst only
//   undefined : perf_stall_cnt_o tied to 0, no counter flops
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   flush_i           discard all entries (redirect)
//   in_valid_i        fetch presents a pair
//   in_pc_i           fetched PC
//   in_instr_i        fetched instruction
//   pc_en_o           buffer can accept (program counter enable)
//   out_valid_o       head entry valid
//   out_pc_o          head PC
//   out_instr_o       head instruction
//   out_ready_i       Decode accepts head
//   count_o           occupancy
//   perf_stall_cnt_o  stall-cycle counter
module fetch_buffer
  import defines::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic [DATA_WIDTH-1:0]    in_pc_i,
  input  logic [DATA_WIDTH-1:0]    in_instr_i,
  output logic                     pc_en_o,
  output logic                     out_valid_o,
  output logic [DATA_WIDTH-1:0]    out_pc_o,
  output logic [DATA_WIDTH-1:0]    out_instr_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              perf_stall_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // pc_en_o looks only at registered occupancy, so a pop while full does not
  // open the door for a push in the same cycle.
  assign pc_en_o     = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;
  assign out_pc_o    = mem_q[rd_ptr_q].pc;
  assign out_instr_o = mem_q[rd_ptr_q].instr;

  assign push = in_valid_i && pc_en_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // Clearing storage keeps the stale head defined (zero) after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q].pc    <= in_pc_i;
        mem_q[wr_ptr_q].instr <= in_instr_i;
      end
    end
  end

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (in_valid_i && !pc_en_o && !flush_i && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule
